// File: rtl/point_pkg.sv
// Shared definitions for the pixel point operators: default geometry,
// pipeline latency, unity gain and the unsigned saturation helper.
package point_pkg;

  localparam int DEF_CHANNELS    = 3;
  localparam int DEF_COLOR_WIDTH = 8;
  localparam int DEF_GAIN_WIDTH  = 16;
  localparam int DEF_FRAC_BITS   = 12;
  localparam int DEF_MUL_STAGES  = 2;

  // Input register + multiplier registers + output register.
  localparam int LATENCY = DEF_MUL_STAGES + 2;

  function automatic int pipe_latency(input int mul_stages);
    return mul_stages + 2;
  endfunction

  function automatic logic [31:0] unity_gain(input int frac_bits);
    return 32'd1 << frac_bits;
  endfunction

  // Clamp a signed value into [0, 2^width-1]; callers truncate to their width.
  function automatic logic [31:0] sat_unsigned(input logic signed [63:0] value,
                                               input int unsigned width);
    logic signed [63:0] max_val;
    max_val = (64'sd1 <<< width) - 64'sd1;
    if (value < 64'sd0)
      return 32'd0;
    else if (value > max_val)
      return max_val[31:0];
    else
      return value[31:0];
  endfunction

endpackage

// File: rtl/point_gain_offset_lane.sv
// One colour channel: pipelined multiply, round-half-up, signed offset and
// saturation, all advancing together on the shared stall enable.
module point_gain_offset_lane
  import point_pkg::*;
#(
  parameter int COLOR_WIDTH = DEF_COLOR_WIDTH,
  parameter int GAIN_WIDTH  = DEF_GAIN_WIDTH,
  parameter int FRAC_BITS   = DEF_FRAC_BITS,
  parameter int MUL_STAGES  = DEF_MUL_STAGES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [COLOR_WIDTH-1:0] pix,
  input  logic [GAIN_WIDTH-1:0]  gain,
  input  logic [COLOR_WIDTH:0]   offset,
  output logic [COLOR_WIDTH-1:0] result
);

  localparam int PW = COLOR_WIDTH + GAIN_WIDTH;
  localparam int RW = PW - FRAC_BITS + 1;
  localparam int SW = PW - FRAC_BITS + 2;
  localparam logic [PW:0] HALF = {{PW{1'b0}}, 1'b1} << (FRAC_BITS - 1);

  logic [PW-1:0]          prod_comb;
  logic [PW-1:0]          prod_last;
  logic [COLOR_WIDTH:0]   off_last;
  logic [RW-1:0]          rounded;
  logic signed [SW-1:0]   summed;

  assign prod_comb = PW'(pix) * PW'(gain);

  // The offset travels with its product so each beat keeps its own coefficients.
  generate
    if (MUL_STAGES == 0) begin : g_nopipe
      assign prod_last = prod_comb;
      assign off_last  = offset;
    end else begin : g_pipe
      logic [PW-1:0]        prod_q [MUL_STAGES];
      logic [COLOR_WIDTH:0] off_q  [MUL_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < MUL_STAGES; k++) begin
            prod_q[k] <= '0;
            off_q[k]  <= '0;
          end
        end else if (en) begin
          prod_q[0] <= prod_comb;
          off_q[0]  <= offset;
          for (int k = 1; k < MUL_STAGES; k++) begin
            prod_q[k] <= prod_q[k-1];
            off_q[k]  <= off_q[k-1];
          end
        end
      end

      assign prod_last = prod_q[MUL_STAGES-1];
      assign off_last  = off_q[MUL_STAGES-1];
    end
  endgenerate

  // One spare bit in the rounding sum keeps a full-scale product from wrapping.
  assign rounded = RW'(({1'b0, prod_last} + HALF) >> FRAC_BITS);
  assign summed  = $signed({1'b0, rounded})
                 + $signed({{(SW-COLOR_WIDTH-1){off_last[COLOR_WIDTH]}}, off_last});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      result <= '0;
    else if (en)
      result <= COLOR_WIDTH'(sat_unsigned({{(64-SW){summed[SW-1]}}, summed}, COLOR_WIDTH));
  end

endmodule

// File: rtl/point_gain_offset.sv
// Streaming per-channel gain/offset operator with frame-synchronous
// double-buffered coefficients and a single global stall enable.
module point_gain_offset
  import point_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int COLOR_WIDTH = DEF_COLOR_WIDTH,
  parameter int GAIN_WIDTH  = DEF_GAIN_WIDTH,
  parameter int FRAC_BITS   = DEF_FRAC_BITS,
  parameter int MUL_STAGES  = DEF_MUL_STAGES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [GAIN_WIDTH-1:0]           cfg_gain,
  input  logic [COLOR_WIDTH:0]            cfg_offset,
  input  logic                            cfg_update,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sof,
  input  logic [CHANNELS*COLOR_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sof,
  output logic [CHANNELS*COLOR_WIDTH-1:0] out_data,
  output logic                            busy
);

  localparam int DEPTH = pipe_latency(MUL_STAGES);
  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_gain(FRAC_BITS));

  logic                            en;
  logic                            accept;
  logic                            sof_accept;
  logic                            pending;
  logic [GAIN_WIDTH-1:0]           active_gain;
  logic [GAIN_WIDTH-1:0]           shadow_gain;
  logic [GAIN_WIDTH-1:0]           beat_gain;
  logic [GAIN_WIDTH-1:0]           s0_gain;
  logic [COLOR_WIDTH:0]            active_offset;
  logic [COLOR_WIDTH:0]            shadow_offset;
  logic [COLOR_WIDTH:0]            beat_offset;
  logic [COLOR_WIDTH:0]            s0_offset;
  logic [CHANNELS*COLOR_WIDTH-1:0] s0_data;
  logic [CHANNELS*COLOR_WIDTH-1:0] lane_out;
  logic [DEPTH-1:0]                valid_pipe;
  logic [DEPTH-1:0]                sof_pipe;

  assign out_valid  = valid_pipe[DEPTH-1];
  assign en         = !out_valid || out_ready;
  assign in_ready   = en;
  assign accept     = in_valid && en;
  assign sof_accept = accept && in_sof;

  // A frame-start beat picks up fresh coefficients; a same-cycle update wins over the shadow.
  always_comb begin
    beat_gain   = active_gain;
    beat_offset = active_offset;
    if (sof_accept && cfg_update) begin
      beat_gain   = cfg_gain;
      beat_offset = cfg_offset;
    end else if (sof_accept && pending) begin
      beat_gain   = shadow_gain;
      beat_offset = shadow_offset;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_gain   <= UNITY;
      active_offset <= '0;
      shadow_gain   <= UNITY;
      shadow_offset <= '0;
      pending       <= 1'b0;
    end else begin
      if (sof_accept && (pending || cfg_update)) begin
        active_gain   <= beat_gain;
        active_offset <= beat_offset;
      end
      if (cfg_update) begin
        shadow_gain   <= cfg_gain;
        shadow_offset <= cfg_offset;
      end
      if (sof_accept)
        pending <= 1'b0;
      else if (cfg_update)
        pending <= 1'b1;
    end
  end

  // Bubbles flow through as zero valids; nothing moves while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe <= '0;
      sof_pipe   <= '0;
      s0_data    <= '0;
      s0_gain    <= UNITY;
      s0_offset  <= '0;
    end else if (en) begin
      valid_pipe <= {valid_pipe[DEPTH-2:0], in_valid};
      sof_pipe   <= {sof_pipe[DEPTH-2:0], in_valid && in_sof};
      s0_data    <= in_data;
      s0_gain    <= beat_gain;
      s0_offset  <= beat_offset;
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      point_gain_offset_lane #(
        .COLOR_WIDTH (COLOR_WIDTH),
        .GAIN_WIDTH  (GAIN_WIDTH),
        .FRAC_BITS   (FRAC_BITS),
        .MUL_STAGES  (MUL_STAGES)
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .pix    (s0_data[i*COLOR_WIDTH +: COLOR_WIDTH]),
        .gain   (s0_gain),
        .offset (s0_offset),
        .result (lane_out[i*COLOR_WIDTH +: COLOR_WIDTH])
      );
    end
  endgenerate

  assign out_sof  = sof_pipe[DEPTH-1];
  assign out_data = out_valid ? lane_out : '0;
  assign busy     = (|valid_pipe) || pending;

endmodule

// File: tb/tb_point_gain_offset.sv
// Self-checking bench for point_gain_offset: directed scenarios plus a
// randomized phase, all scored against a plain-arithmetic reference model.
module tb_point_gain_offset;
  import point_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] cfg_gain;
  logic [8:0]  cfg_offset;
  logic        cfg_update;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic [23:0] out_data;
  logic        busy;

  typedef struct {
    logic [23:0] data;
    logic        sof;
    bit          has_const;
    logic [23:0] const_data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          m_act_g, m_act_o, m_sh_g, m_sh_o;
  bit          m_pending;
  bit          last_out_valid;
  bit          cur_has_const;
  logic [23:0] cur_const;

  point_gain_offset dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_gain   (cfg_gain),
    .cfg_offset (cfg_offset),
    .cfg_update (cfg_update),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_data   (out_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // out = clamp(round_half_up(in * gain / 4096) + offset) per 8-bit channel.
  function automatic logic [23:0] model_pixel(input logic [23:0] pix, input int g, input int o);
    logic [23:0] res;
    int x, s;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      x = int'(pix[c*8 +: 8]);
      s = (x * g + 2048) / 4096 + o;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      res[c*8 +: 8] = s[7:0];
    end
    return res;
  endfunction

  task automatic modelReset();
    exp_q.delete();
    m_act_g = 4096; m_act_o = 0;
    m_sh_g = 4096;  m_sh_o = 0;
    m_pending = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: sample and score outputs, advance the model, cross the edge.
  task automatic tick(output bit accepted);
    bit   rdy_exp, acc;
    int   g, o;
    exp_t e;
    #1;
    rdy_exp = !out_valid || out_ready;
    checkOutput("in_ready", 32'(in_ready), 32'(rdy_exp));
    checkOutput("busy", 32'(busy), 32'((exp_q.size() != 0) || m_pending));
    if (out_valid) begin
      checkOutput("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        checkOutput("out_data", 32'(out_data), 32'(exp_q[0].data));
        checkOutput("out_sof", 32'(out_sof), 32'(exp_q[0].sof));
        if (exp_q[0].has_const)
          checkOutput("out_const", 32'(out_data), 32'(exp_q[0].const_data));
      end
    end else begin
      checkOutput("idle_data", 32'(out_data), 32'd0);
      checkOutput("idle_sof", 32'(out_sof), 32'd0);
    end
    last_out_valid = out_valid;
    acc = in_valid && in_ready;
    if (out_valid && out_ready && exp_q.size() != 0)
      void'(exp_q.pop_front());
    g = m_act_g; o = m_act_o;
    if (acc && in_sof) begin
      if (cfg_update) begin
        g = int'(cfg_gain); o = int'($signed(cfg_offset));
      end else if (m_pending) begin
        g = m_sh_g; o = m_sh_o;
      end
      m_act_g = g; m_act_o = o;
      m_pending = 1'b0;
    end
    if (cfg_update) begin
      m_sh_g = int'(cfg_gain); m_sh_o = int'($signed(cfg_offset));
      if (!(acc && in_sof)) m_pending = 1'b1;
    end
    if (acc) begin
      e.data = model_pixel(in_data, g, o);
      e.sof = in_sof;
      e.has_const = cur_has_const;
      e.const_data = cur_const;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    accepted = acc;
  endtask

  task automatic applyStimulus(input bit sof, input logic [23:0] data, input bit upd,
                               input int gain, input int off, input bit hc, input logic [23:0] cd);
    bit acc;
    int guard;
    guard = 0;
    in_valid = 1'b1; in_sof = sof; in_data = data;
    cfg_update = upd; cfg_gain = gain[15:0]; cfg_offset = off[8:0];
    cur_has_const = hc; cur_const = cd;
    do begin
      tick(acc);
      cfg_update = 1'b0;
      guard++;
    end while (!acc && guard < 50);
    checkOutput("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0; in_sof = 1'b0; cur_has_const = 1'b0;
  endtask

  task automatic configure(input int gain, input int off);
    bit acc;
    in_valid = 1'b0;
    cfg_update = 1'b1; cfg_gain = gain[15:0]; cfg_offset = off[8:0];
    tick(acc);
    cfg_update = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    int guard;
    guard = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 40) begin
      tick(acc);
      guard++;
    end
    checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
    tick(acc);
  endtask

  task automatic measureLatency(input string tag);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b0;
    do begin
      tick(acc);
      n++;
    end while (!last_out_valid && n < 20);
    checkOutput(tag, 32'(n), 32'(LATENCY));
  endtask

  initial begin
    bit acc, holding;
    int idx, nbeats;
    rst_n = 1'b0; cfg_gain = '0; cfg_offset = '0; cfg_update = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
    cur_has_const = 1'b0; cur_const = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_sof", 32'(out_sof), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] identity after reset");
    applyStimulus(1'b1, 24'h8010FF, 1'b0, 0, 0, 1'b1, 24'h8010FF);
    measureLatency("latency_first");
    applyStimulus(1'b0, 24'h0001FE, 1'b0, 0, 0, 1'b1, 24'h0001FE);
    measureLatency("latency_second");
    drain();

    $display("[TB] gain 1.5 offset 0");
    configure(32'h1800, 0);
    applyStimulus(1'b1, {8'd0, 8'd200, 8'd100}, 1'b0, 0, 0, 1'b1, {8'd0, 8'd255, 8'd150});
    drain();

    $display("[TB] gain 0.5 offset -20");
    configure(32'h0800, -20);
    applyStimulus(1'b1, {8'd255, 8'd30, 8'd101}, 1'b0, 0, 0, 1'b1, {8'd108, 8'd0, 8'd31});
    drain();

    $display("[TB] backpressure");
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 10; cyc++) begin
      in_valid = 1'b1;
      in_sof = (idx == 0);
      in_data = {8'(idx * 7), 8'(idx * 19 + 3), 8'(idx * 25)};
      out_ready = !(cyc >= 4 && cyc < 9);
      tick(acc);
      if (acc) idx++;
    end
    checkOutput("bp_all_sent", 32'(idx), 32'd10);
    drain();

    $display("[TB] shadow timing");
    configure(4096, 0);
    applyStimulus(1'b1, {3{8'd200}}, 1'b0, 0, 0, 1'b1, {3{8'd200}});
    applyStimulus(1'b0, {3{8'd200}}, 1'b1, 2048, 0, 1'b1, {3{8'd200}});
    applyStimulus(1'b0, {3{8'd200}}, 1'b0, 0, 0, 1'b1, {3{8'd200}});
    applyStimulus(1'b1, {3{8'd200}}, 1'b0, 0, 0, 1'b1, {3{8'd100}});
    drain();
    configure(4096, 0);
    applyStimulus(1'b1, {3{8'd200}}, 1'b1, 2048, 0, 1'b1, {3{8'd100}});
    applyStimulus(1'b0, {3{8'd200}}, 1'b0, 0, 0, 1'b1, {3{8'd100}});
    drain();

    $display("[TB] reset mid-stream");
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 24'($urandom), 1'b0, 0, 0, 1'b0, 24'h0);
    checkOutput("busy_before_reset", 32'(busy), 32'(exp_q.size() != 0));
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    applyStimulus(1'b1, {3{8'd77}}, 1'b0, 0, 0, 1'b1, {3{8'd77}});
    drain();

    $display("[TB] randomized traffic");
    holding = 1'b0;
    nbeats = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!holding && ($urandom % 4) != 0) begin
        in_valid = 1'b1;
        in_data = 24'($urandom);
        in_sof = (nbeats % 6 == 0);
        holding = 1'b1;
      end
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 10 == 0) begin
        cfg_update = 1'b1;
        cfg_gain = 16'($urandom_range(0, 12288));
        cfg_offset = 9'($urandom);
      end
      tick(acc);
      cfg_update = 1'b0;
      if (acc) begin
        holding = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        nbeats++;
      end
    end
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
